// File: rtl/rr_mux4way16.sv
// Round-robin merge of four 16-bit source channels into one registered output slot.
// The grant pointer rotates past the most recently granted channel, so every requester is served in turn.
module rr_mux4way16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [3:0]  valid_in,
  output logic [3:0]  ready_out,
  output logic [15:0] out,
  output logic [1:0]  out_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] count
);

  // state | meaning
  // EMPTY | output slot holds no undelivered word
  // FULL  | out/out_sel hold a word waiting for the sink
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] out_q, out_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] count_q, count_d;

  logic [1:0]  cand;
  logic [1:0]  grant_idx;
  logic        grant_any;
  logic        can_accept;
  logic        src_xfer;
  logic [15:0] grant_data;

  // Search starts one past the last grant and wraps, giving a rotating priority.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_q;
    cand      = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!grant_any && valid_in[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_data = in0;
    case (grant_idx)
      2'd0: grant_data = in0;
      2'd1: grant_data = in1;
      2'd2: grant_data = in2;
      2'd3: grant_data = in3;
      default: grant_data = in0;
    endcase
  end

  assign can_accept = (state_q == EMPTY) || out_ready;
  // Gated by reset so no grant is offered while the block is held in reset.
  assign ready_out  = (grant_any && can_accept && !reset) ? (4'b0001 << grant_idx) : 4'b0000;
  assign src_xfer   = |ready_out;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    last_d  = last_q;
    count_d = count_q;
    if (src_xfer) begin
      state_d = FULL;
      out_d   = grant_data;
      sel_d   = grant_idx;
      last_d  = grant_idx;
      count_d = count_q + 16'd1;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      out_q   <= 16'h0000;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = sel_q;
  assign out_valid = (state_q == FULL);
  assign count     = count_q;

endmodule

// File: tb/tb_rr_mux4way16.sv
// Directed bench for rr_mux4way16: a vector table of single-cycle steps plus
// hand-written sequences for asynchronous reset and count wrap.
module tb_rr_mux4way16;

  logic        clk;
  logic        reset;
  logic [15:0] in0, in1, in2, in3;
  logic [3:0]  valid_in;
  logic [3:0]  ready_out;
  logic [15:0] out;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux4way16 dut (
    .clk(clk), .reset(reset),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .valid_in(valid_in), .ready_out(ready_out),
    .out(out), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_rst;
    logic [3:0]  vi;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_out;
    logic [1:0]  exp_sel;
    logic        exp_v;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    // in2=FFFF for the single-channel case; others give distinct patterns
    in0 = 16'hA5A5; in1 = 16'h5A5A; in2 = 16'hFFFF; in3 = 16'h0000;

    //         rst   vi       ordy  rdy      out       sel  v     cnt
    vecs[0]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 16'hFFFF, 2'd2, 1'b1, 16'd1};
    vecs[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 16'hFFFF, 2'd2, 1'b0, 16'd1};
    vecs[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 16'hFFFF, 2'd2, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 16'hA5A5, 2'd0, 1'b1, 16'd1};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 16'h5A5A, 2'd1, 1'b1, 16'd2};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 16'hFFFF, 2'd2, 1'b1, 16'd3};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 16'h0000, 2'd3, 1'b1, 16'd4};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 16'hA5A5, 2'd0, 1'b1, 16'd5};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 16'h5A5A, 2'd1, 1'b1, 16'd6};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 16'hFFFF, 2'd2, 1'b1, 16'd7};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 16'h0000, 2'd3, 1'b1, 16'd8};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 16'hA5A5, 2'd0, 1'b1, 16'd9};
    vecs[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b1, 16'd9};
    vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b1, 16'd9};
    vecs[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b1, 16'd9};
    vecs[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b1, 16'd9};
    vecs[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b1, 16'd9};
    vecs[17] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 16'h5A5A, 2'd1, 1'b1, 16'd10};
    vecs[18] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 16'hA5A5, 2'd0, 1'b1, 16'd11};
    vecs[19] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 16'h0000, 2'd3, 1'b1, 16'd12};
    vecs[20] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 16'hA5A5, 2'd0, 1'b1, 16'd13};
    vecs[21] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b1, 16'd13};
    vecs[22] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b1, 16'd13};
    vecs[23] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 16'h5A5A, 2'd1, 1'b1, 16'd14};

    // Reset values, with requests present to show no grant during reset
    reset = 1'b1; valid_in = 4'b1111; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out", out, 16'h0000);
    check("rst_out_sel", {14'd0, out_sel}, 16'd0);
    check("rst_count", count, 16'h0000);
    check("rst_ready_out", {12'd0, ready_out}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (vecs[i].do_rst) pulse_reset();
      valid_in  = vecs[i].vi;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_ready_out", i), {12'd0, ready_out}, {12'd0, vecs[i].exp_rdy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("v%0d_out_sel", i), {14'd0, out_sel}, {14'd0, vecs[i].exp_sel});
      check($sformatf("v%0d_out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].exp_v});
      check($sformatf("v%0d_count", i), count, vecs[i].exp_cnt);
    end

    // Asynchronous reset between edges while FULL: effect must be immediate
    @(negedge clk);
    valid_in = 4'b1111; out_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("async_out_valid", {15'd0, out_valid}, 16'd0);
    check("async_out", out, 16'h0000);
    check("async_count", count, 16'h0000);
    check("async_ready_out", {12'd0, ready_out}, 16'd0);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_ready_out", {12'd0, ready_out}, 16'h0001);
    @(posedge clk);
    #1;
    check("post_rst_out_sel", {14'd0, out_sel}, 16'd0);
    check("post_rst_count", count, 16'd1);

    // Count wrap: 65536 accepted words from reset returns count to zero
    @(negedge clk);
    pulse_reset();
    valid_in = 4'b1111; out_ready = 1'b1;
    for (int n = 0; n < 65535; n++) @(posedge clk);
    #1;
    check("wrap_count_ffff", count, 16'hFFFF);
    check("wrap_sel_before", {14'd0, out_sel}, 16'd2);
    @(posedge clk);
    #1;
    check("wrap_count_zero", count, 16'h0000);
    check("wrap_sel_after", {14'd0, out_sel}, 16'd3);
    check("wrap_out", out, 16'h0000);
    check("wrap_out_valid", {15'd0, out_valid}, 16'd1);
    @(posedge clk);
    #1;
    check("wrap_next_sel", {14'd0, out_sel}, 16'd0);
    check("wrap_next_count", count, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
